fpu_result_txq: RTL and testbench
=================================

# fpu_result_txq

Result transmit queue that sits directly downstream of the FPU core. It captures each 32-bit result reported by a single-cycle result-valid pulse into a small FIFO. It then streams every result out as a byte-serial frame, MSB first, to the output pins, with a valid/ack handshake so the host can pace reads. A sticky overflow flag records results lost while the queue was full.

## Interface

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low (already decided, fixed).
- res_data  input  32  FPU result word (IEEE-754 single).
- res_valid  input  1  one-cycle pulse: res_data is valid this cycle.
- byte_out  output  8  current output byte.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ack  input  1  host consumed byte_out; only meaningful while byte_valid=1.
- frame_start  output  1  high while byte_out is the first byte of a frame.
- fifo_full  output  1  all DEPTH entries occupied.
- fifo_level  output  LVL_W  number of occupied entries, 0..DEPTH.
- overflow  output  1  sticky: at least one result was dropped.

## Operation

- Reset (rst_n=0, asynchronous) clears every output to 0: byte_out=0x00, byte_valid=0, frame_start=0, fifo_full=0, fifo_level=0, overflow=0. It also empties the FIFO, clears the pointers and the byte index, and forces state IDLE.
- Push: on an edge with res_valid=1, res_data is written at the tail when the FIFO is not full after any same-edge pop.
- A push while full with no same-edge pop drops the word and sets overflow. Overflow stays set until reset.
- Pop: the head word leaves the FIFO on the same edge it is loaded into the 32-bit shift register.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_level is tracked as a separate counter; a simultaneous push and pop leaves it unchanged.
- Serializer FSM:
  - IDLE: byte_valid=0. If the FIFO is non-empty, load and pop the head word, set byte index to 3, and go to SEND.
  - SEND: byte_out = word[8*idx+7 : 8*idx], byte_valid=1, frame_start = (idx==3).
    - On byte_ack=1, decrement idx.
    - On ack of idx 0: go to CSUM (macro on). With the macro off, reload directly if the FIFO is non-empty (stay in SEND, idx=3), else go to IDLE.
  - CSUM (macro only): byte_out = XOR of the 4 frame bytes, frame_start=0. On ack, take the same reload/IDLE decision as above.
- byte_out, byte_valid and frame_start are registered and stay stable while byte_valid=1 and byte_ack=0.
- byte_ack while byte_valid=0 is ignored.

## Timing

- res_valid sampled at edge k, with the FIFO empty and the FSM in IDLE: the word is in the FIFO after edge k, and the first byte (byte_valid=1, frame_start=1) is visible after edge k+1.
- Back-to-back frames have zero bubble: when the last byte is acked at edge m and the FIFO is non-empty, the next frame's first byte is visible after edge m.
- Full-rate throughput is one byte per cycle with byte_ack held at 1. A frame takes 4 cycles (5 with checksum).
- Push and pop on the same edge while full: the push is accepted, no overflow, and fifo_level stays at DEPTH.
- Reset asserted mid-frame: the partial frame is abandoned and outputs clear immediately, without waiting for a clock edge.

## Configuration

- FPU_TXQ_CHECKSUM_EN defined: each frame is 5 bytes. After the 4 data bytes comes a fifth byte equal to b3^b2^b1^b0, sent from state CSUM.
- FPU_TXQ_CHECKSUM_EN undefined: each frame is exactly 4 bytes, and the CSUM state and XOR logic are not built.

## Test plan

- Reset then idle: all outputs are 0, and byte_ack pulses have no effect.
- Single result 0x3FC00000 with byte_ack held at 1: bytes 0x3F, 0x C0, 0x00, 0x00 on consecutive cycles, with frame_start high only on 0x3F. With the macro on, a fifth byte 0xFF follows.
- Backpressure: push 0x40490FDB and hold byte_ack=0 for 5 cycles: byte_out stays 0x40 and byte_valid stays 1. Then ack: 0x49, 0x0F, 0xDB follow.
- Overflow: with DEPTH=4 and byte_ack=0, push 6 distinct words. Result: fifo_level=4, fifo_full=1, overflow=1. Releasing ack outputs only the first 5 words (one word in the shift register plus 4 in the FIFO), in order.
- Simultaneous push and pop at full: the push is accepted on the edge where the last byte is acked, overflow stays 0, and all words emerge in order.
- Reset mid-frame after 2 bytes: outputs clear, fifo_level=0, and the next pushed word starts a fresh frame at its MSB.

Source files
------------

// File: rtl/fpu_result_txq.sv
// Queues FPU results and streams each as an MSB-first byte frame; optional XOR checksum byte under FPU_TXQ_CHECKSUM_EN.
// Latency: first byte visible two edges after res_valid into an empty, idle queue; back-to-back frames have no bubble.
// Backpressure: byte outputs hold while byte_ack=0; results arriving while the queue stays full are dropped and set sticky overflow.

module fpu_txq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic [W-1:0]     head_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             pop_en;
    logic             push_en;

    assign full     = (cnt == LVL_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign level    = cnt;
    assign head_dat = mem[rd_ptr];
    assign pop_en   = pop_rdy && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign push_en  = push_vld && (!full || pop_en);
    assign drop     = push_vld && full && !pop_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_dat;
    end
endmodule

module fpu_result_txq #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      res_data,
    input  logic             res_valid,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ack,
    output logic             frame_start,
    output logic             fifo_full,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef FPU_TXQ_CHECKSUM_EN
    localparam logic [1:0] ST_CSUM = 2'd2;
`endif

    logic [1:0]  state, state_n;
    logic [1:0]  idx, idx_n;
    logic [1:0]  idx_dec;
    logic [31:0] shift_word, shift_word_n;
    logic [7:0]  byte_out_n;
    logic        byte_valid_n;
    logic        frame_start_n;
    logic [31:0] head_dat;
    logic        fifo_empty;
    logic        fifo_drop;
    logic        last_ack;
    logic        load;

    fpu_txq_fifo #(
        .W     (32),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (res_valid),
        .push_dat (res_data),
        .pop_rdy  (load),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .drop     (fifo_drop)
    );

`ifdef FPU_TXQ_CHECKSUM_EN
    assign last_ack = (state == ST_CSUM) && byte_ack;
`else
    assign last_ack = (state == ST_SEND) && byte_ack && (idx == 2'd0);
`endif
    // Reloading on the final ack gives zero-bubble back-to-back frames.
    assign load    = !fifo_empty && ((state == ST_IDLE) || last_ack);
    assign idx_dec = idx - 2'd1;

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        shift_word_n  = shift_word;
        byte_out_n    = byte_out;
        byte_valid_n  = byte_valid;
        frame_start_n = frame_start;
        if (load) begin
            state_n       = ST_SEND;
            idx_n         = 2'd3;
            shift_word_n  = head_dat;
            byte_out_n    = head_dat[31:24];
            byte_valid_n  = 1'b1;
            frame_start_n = 1'b1;
        end else if (last_ack) begin
            state_n       = ST_IDLE;
            byte_out_n    = 8'h00;
            byte_valid_n  = 1'b0;
            frame_start_n = 1'b0;
        end else if ((state == ST_SEND) && byte_ack) begin
            frame_start_n = 1'b0;
            if (idx != 2'd0) begin
                idx_n      = idx_dec;
                byte_out_n = shift_word[{idx_dec, 3'b000} +: 8];
            end
`ifdef FPU_TXQ_CHECKSUM_EN
            else begin
                state_n    = ST_CSUM;
                byte_out_n = shift_word[31:24] ^ shift_word[23:16]
                           ^ shift_word[15:8]  ^ shift_word[7:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            shift_word  <= 32'h0;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            shift_word  <= shift_word_n;
            byte_out    <= byte_out_n;
            byte_valid  <= byte_valid_n;
            frame_start <= frame_start_n;
            if (fifo_drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_result_txq.sv
// Directed bench for fpu_result_txq (DEPTH=4); handles both checksum build options.
module tb_fpu_result_txq;
    logic        clk;
    logic        rst_n;
    logic [31:0] res_data;
    logic        res_valid;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ack;
    logic        frame_start;
    logic        fifo_full;
    logic [2:0]  fifo_level;
    logic        overflow;

    int checks = 0;
    int passed = 0;

    fpu_result_txq #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ack    (byte_ack),
        .frame_start (frame_start),
        .fifo_full   (fifo_full),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expects the frame's first byte to be visible now and byte_ack held at 1.
    task automatic read_word(input string tag, input logic [31:0] w);
        logic [7:0] cs;
        cs = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        for (int i = 3; i >= 0; i--) begin
            check({tag, "_vld"}, {31'h0, byte_valid}, 32'h1);
            check({tag, "_byte"}, {24'h0, byte_out}, {24'h0, w[8*i +: 8]});
            check({tag, "_fs"}, {31'h0, frame_start}, (i == 3) ? 32'h1 : 32'h0);
            step();
        end
`ifdef FPU_TXQ_CHECKSUM_EN
        check({tag, "_csum"}, {24'h0, byte_out}, {24'h0, cs});
        check({tag, "_csum_fs"}, {31'h0, frame_start}, 32'h0);
        step();
`endif
    endtask

    logic [31:0] words [6];
    int          nb;

    initial begin
        words[0] = 32'h01020304;
        words[1] = 32'h11121314;
        words[2] = 32'h21222324;
        words[3] = 32'h31323334;
        words[4] = 32'h41424344;
        words[5] = 32'h51525354;
`ifdef FPU_TXQ_CHECKSUM_EN
        nb = 5;
`else
        nb = 4;
`endif
        rst_n = 1'b0; res_valid = 1'b0; res_data = 32'h0; byte_ack = 1'b0;
        #3;
        check("rst_byte_out", {24'h0, byte_out}, 32'h0);
        check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("rst_frame_start", {31'h0, frame_start}, 32'h0);
        check("rst_fifo_full", {31'h0, fifo_full}, 32'h0);
        check("rst_fifo_level", {29'h0, fifo_level}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        #9 rst_n = 1'b1;
        step();

        // Acks while idle are ignored
        byte_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ack_vld", {31'h0, byte_valid}, 32'h0);
            check("idle_ack_lvl", {29'h0, fifo_level}, 32'h0);
        end

        // Single result at full rate
        res_valid = 1'b1; res_data = 32'h3FC00000;
        step();
        res_valid = 1'b0;
        check("single_lvl_k", {29'h0, fifo_level}, 32'h1);
        check("single_vld_k", {31'h0, byte_valid}, 32'h0);
        step();
        check("single_lvl_k1", {29'h0, fifo_level}, 32'h0);
        read_word("single", 32'h3FC00000);
        check("single_done_vld", {31'h0, byte_valid}, 32'h0);

        // Backpressure hold
        byte_ack = 1'b0;
        res_valid = 1'b1; res_data = 32'h40490FDB;
        step();
        res_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_byte", {24'h0, byte_out}, 32'h40);
            check("bp_hold_vld", {31'h0, byte_valid}, 32'h1);
        end
        byte_ack = 1'b1;
        read_word("bp", 32'h40490FDB);
        check("bp_done_vld", {31'h0, byte_valid}, 32'h0);

        // Overflow: six pushes with ack held low
        byte_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_valid = 1'b1; res_data = words[i];
            step();
        end
        res_valid = 1'b0;
        check("ovf_level", {29'h0, fifo_level}, 32'h4);
        check("ovf_full", {31'h0, fifo_full}, 32'h1);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        byte_ack = 1'b1;
        for (int i = 0; i < 5; i++) read_word("ovf_drain", words[i]);
        check("ovf_drain_vld", {31'h0, byte_valid}, 32'h0);
        check("ovf_drain_lvl", {29'h0, fifo_level}, 32'h0);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Reset mid-frame after two bytes
        res_valid = 1'b1; res_data = 32'hCAFEBABE;
        step();
        res_data = 32'hDEADBEEF;
        step();
        res_valid = 1'b0;
        check("mid_first", {24'h0, byte_out}, 32'hCA);
        check("mid_lvl", {29'h0, fifo_level}, 32'h1);
        step();
        check("mid_second", {24'h0, byte_out}, 32'hFE);
        step();
        check("mid_third", {24'h0, byte_out}, 32'hBA);
        rst_n = 1'b0;
        #1;
        check("mid_rst_byte", {24'h0, byte_out}, 32'h0);
        check("mid_rst_vld", {31'h0, byte_valid}, 32'h0);
        check("mid_rst_fs", {31'h0, frame_start}, 32'h0);
        check("mid_rst_lvl", {29'h0, fifo_level}, 32'h0);
        check("mid_rst_ovf", {31'h0, overflow}, 32'h0);
        #2 rst_n = 1'b1;
        step();
        res_valid = 1'b1; res_data = 32'h12345678;
        step();
        res_valid = 1'b0;
        step();
        read_word("post_rst", 32'h12345678);
        check("post_rst_vld", {31'h0, byte_valid}, 32'h0);

        // Push and pop on the same edge while full
        byte_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1; res_data = words[i];
            step();
        end
        res_valid = 1'b0;
        check("pp_full_lvl", {29'h0, fifo_level}, 32'h4);
        check("pp_full_ovf", {31'h0, overflow}, 32'h0);
        byte_ack = 1'b1;
        for (int i = 0; i < nb - 1; i++) begin
            check("pp_w0_vld", {31'h0, byte_valid}, 32'h1);
            step();
        end
        res_valid = 1'b1; res_data = words[5];
        step();
        res_valid = 1'b0;
        check("pp_lvl", {29'h0, fifo_level}, 32'h4);
        check("pp_full", {31'h0, fifo_full}, 32'h1);
        check("pp_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 1; i < 6; i++) read_word("pp_drain", words[i]);
        check("pp_done_vld", {31'h0, byte_valid}, 32'h0);
        check("pp_done_lvl", {29'h0, fifo_level}, 32'h0);
        check("pp_done_ovf", {31'h0, overflow}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
